// File: rtl/adder_share_arb_pkg.sv
// Shared constants and payload types for the two-port shared adder arbiter.
package adder_share_arb_pkg;

    localparam int unsigned NUM_PORTS = 2;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned PORT_ALU  = 0;
    localparam int unsigned PORT_ADDR = 1;

    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_V = 0;

    // Condition flags returned with each result, packed as {N,Z,V}
    typedef struct packed {
        logic n;
        logic z;
        logic v;
    } flags_t;

endpackage

// File: rtl/adder_share_arb_rr_arb2.sv
// Two-requester round-robin arbiter with per-port starvation force-grant.
module rr_arb2 #(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    input  logic [1:0] elig,
    output logic [1:0] grant_c
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic                  rr_q;
    logic                  rr_d;
    logic [1:0][CNT_W-1:0] starve_q;
    logic [1:0][CNT_W-1:0] starve_d;

    // Grant selection: starved port first, then rr on contention, else the lone requester
    always_comb begin
        grant_c = 2'b00;
        if (!rst_n) begin
            grant_c = 2'b00;
        end else if (elig[0] && (starve_q[0] == CNT_MAX)) begin
            grant_c = 2'b01;
        end else if (elig[1] && (starve_q[1] == CNT_MAX)) begin
            grant_c = 2'b10;
        end else if (elig == 2'b11) begin
            grant_c = rr_q ? 2'b10 : 2'b01;
        end else begin
            grant_c = elig;
        end
    end

    // Pointer moves to the other port after a grant; counters track denied cycles
    always_comb begin
        rr_d     = rr_q;
        starve_d = starve_q;
        if (grant_c[0]) begin
            rr_d = 1'b1;
        end else if (grant_c[1]) begin
            rr_d = 1'b0;
        end
        for (int p = 0; p < 2; p++) begin
            if (grant_c[p] || !req_valid[p]) begin
                starve_d[p] = '0;
            end else if (elig[p] && (starve_q[p] != CNT_MAX)) begin
                starve_d[p] = starve_q[p] + CNT_W'(1);
            end
        end
    end

    // Arbiter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q     <= 1'b0;
            starve_q <= '0;
        end else begin
            rr_q     <= rr_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/cla_16bit.sv
// 16-bit carry-lookahead add/sub with signed saturation of the result.
module cla_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] b_eff;
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] raw;
    logic [16:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  cg;
    logic        ovf;

    // Two-level lookahead: 4-bit group generate/propagate, then in-group carries
    always_comb begin
        b_eff = sub ? ~b : b;
        g     = a & b_eff;
        p     = a ^ b_eff;
        gg    = '0;
        gp    = '0;
        for (int k = 0; k < 4; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
        cg    = '0;
        cg[0] = sub;
        for (int k = 0; k < 4; k++) begin
            cg[k+1] = gg[k] | (gp[k] & cg[k]);
        end
        c = '0;
        for (int k = 0; k < 4; k++) begin
            c[4*k] = cg[k];
            for (int j = 0; j < 4; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
        end
        raw  = p ^ c[15:0];
        cout = c[16];
        ovf  = c[16] ^ c[15];
        // Positive overflow wraps negative, so clamp opposite to the raw sign
        if (ovf) begin
            sum = raw[15] ? 16'h7FFF : 16'h8000;
        end else begin
            sum = raw;
        end
    end

endmodule

// File: rtl/adder_share_arb.sv
// Shares one saturating 16-bit add/sub unit between an ALU port (0) and an
// address port (1), with one held result slot per port.
// Optional macro ADDER_ARB_FLAGS_EN builds the {N,Z,V} flag path; otherwise
// rsp_flags is tied low.
module adder_share_arb
    import adder_share_arb_pkg::*;
#(
    parameter int unsigned W          = 16,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [2*W-1:0] req_a,
    input  logic [2*W-1:0] req_b,
    input  logic [1:0]     req_sub,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [2*W-1:0] rsp_sum,
    output logic [1:0]     rsp_cout,
    output logic [5:0]     rsp_flags
);

    logic [1:0]     elig_c;
    logic [1:0]     grant_c;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic           add_sub;
    logic [W-1:0]   add_sum;
    logic           add_cout;

    logic [1:0]     rsp_valid_q;
    logic [1:0]     rsp_valid_d;
    logic [2*W-1:0] rsp_sum_q;
    logic [2*W-1:0] rsp_sum_d;
    logic [1:0]     rsp_cout_q;
    logic [1:0]     rsp_cout_d;

    // A port may be granted when its slot is empty or being drained this cycle
    always_comb begin
        elig_c = 2'b00;
        for (int p = 0; p < 2; p++) begin
            elig_c[p] = req_valid[p] & (~rsp_valid_q[p] | rsp_ready[p]);
        end
    end

    rr_arb2 #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .elig      (elig_c),
        .grant_c   (grant_c)
    );

    assign req_ready = grant_c;

    // Steer the granted port's operands into the shared adder, zeros when idle
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        if (grant_c[PORT_ALU]) begin
            add_a   = req_a[PORT_ALU*W +: W];
            add_b   = req_b[PORT_ALU*W +: W];
            add_sub = req_sub[PORT_ALU];
        end else if (grant_c[PORT_ADDR]) begin
            add_a   = req_a[PORT_ADDR*W +: W];
            add_b   = req_b[PORT_ADDR*W +: W];
            add_sub = req_sub[PORT_ADDR];
        end
    end

    cla_16bit u_cla (
        .a    (add_a),
        .b    (add_b),
        .sub  (add_sub),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Slot update: load on transfer, otherwise release when the requester accepts
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        for (int p = 0; p < 2; p++) begin
            if (grant_c[p]) begin
                rsp_valid_d[p]      = 1'b1;
                rsp_sum_d[p*W +: W] = add_sum;
                rsp_cout_d[p]       = add_cout;
            end else if (rsp_valid_q[p] && rsp_ready[p]) begin
                rsp_valid_d[p] = 1'b0;
            end
        end
    end

    // Result slot registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;

`ifdef ADDER_ARB_FLAGS_EN
    logic [W:0]      ext_c;
    flags_t          new_flags_c;
    flags_t [1:0]    flags_q;
    flags_t [1:0]    flags_d;

    // Overflow is judged on the exact result, before saturation
    always_comb begin
        if (add_sub) begin
            ext_c = {add_a[W-1], add_a} - {add_b[W-1], add_b};
        end else begin
            ext_c = {add_a[W-1], add_a} + {add_b[W-1], add_b};
        end
        new_flags_c   = '0;
        new_flags_c.n = add_sum[W-1];
        new_flags_c.z = (add_sum == '0);
        new_flags_c.v = ext_c[W] ^ ext_c[W-1];
    end

    // Flags load with the sum of the same port
    always_comb begin
        flags_d = flags_q;
        for (int p = 0; p < 2; p++) begin
            if (grant_c[p]) begin
                flags_d[p] = new_flags_c;
            end
        end
    end

    // Flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign rsp_flags = flags_q;
`else
    assign rsp_flags = '0;
`endif

endmodule

// File: tb/tb_adder_share_arb.sv
// Randomized + directed bench for adder_share_arb against a transaction-level model.
module tb_adder_share_arb;

    localparam int STARVE = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [1:0]  req_sub;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_sum;
    logic [1:0]  rsp_cout;
    logic [5:0]  rsp_flags;

    adder_share_arb #(.W(16), .STARVE_MAX(STARVE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_flags (rsp_flags)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference state: one result slot per port, fairness pointer, denied-cycle counts
    logic [1:0]  m_v;
    logic [15:0] m_sum [2];
    logic [1:0]  m_cout;
    logic [2:0]  m_fl [2];
    int          m_rr;
    int          m_st [2];
    logic [1:0]  m_last_g;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                                     output logic [15:0] sum, output logic co, output logic [2:0] fl);
        int ea, eb, ex;
        logic [31:0] u;
        ea = int'($signed(a));
        eb = int'($signed(b));
        ex = s ? (ea - eb) : (ea + eb);
        if (ex > 32767)       sum = 16'h7FFF;
        else if (ex < -32768) sum = 16'h8000;
        else                  sum = ex[15:0];
        u  = 32'(a) + (s ? 32'(16'(~b)) : 32'(b)) + 32'(s);
        co = u[16];
`ifdef ADDER_ARB_FLAGS_EN
        fl = {sum[15], (sum == 16'h0000), ((ex > 32767) || (ex < -32768))};
`else
        fl = 3'b000;
`endif
    endfunction

    task automatic model_reset();
        m_v      = 2'b00;
        m_sum[0] = '0;
        m_sum[1] = '0;
        m_cout   = 2'b00;
        m_fl[0]  = '0;
        m_fl[1]  = '0;
        m_rr     = 0;
        m_st[0]  = 0;
        m_st[1]  = 0;
        m_last_g = 2'b00;
    endtask

    // One clock cycle: drive, check all outputs against the model, advance the model
    task automatic step(input logic [1:0] v,
                        input logic [15:0] a0, input logic [15:0] b0, input logic s0,
                        input logic [15:0] a1, input logic [15:0] b1, input logic s1,
                        input logic [1:0] rr_in);
        logic [1:0]  el;
        logic [1:0]  eg;
        logic [15:0] ns;
        logic        nc;
        logic [2:0]  nf;
        @(negedge clk);
        req_valid = v;
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        req_sub   = {s1, s0};
        rsp_ready = rr_in;
        #1;
        for (int p = 0; p < 2; p++) el[p] = v[p] && (!m_v[p] || rr_in[p]);
        if (el[0] && m_st[0] == STARVE)      eg = 2'b01;
        else if (el[1] && m_st[1] == STARVE) eg = 2'b10;
        else if (el == 2'b11)                eg = (m_rr == 0) ? 2'b01 : 2'b10;
        else                                 eg = el;
        chk("req_ready", 32'(req_ready), 32'(eg));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_v));
        chk("rsp_sum0",  32'(rsp_sum[15:0]), 32'(m_sum[0]));
        chk("rsp_sum1",  32'(rsp_sum[31:16]), 32'(m_sum[1]));
        chk("rsp_cout",  32'(rsp_cout), 32'(m_cout));
        chk("rsp_flags", 32'(rsp_flags), 32'({m_fl[1], m_fl[0]}));
        for (int p = 0; p < 2; p++) begin
            if (eg[p]) begin
                if (p == 0) model_op(a0, b0, s0, ns, nc, nf);
                else        model_op(a1, b1, s1, ns, nc, nf);
                m_v[p]    = 1'b1;
                m_sum[p]  = ns;
                m_cout[p] = nc;
                m_fl[p]   = nf;
            end else if (m_v[p] && rr_in[p]) begin
                m_v[p] = 1'b0;
            end
            if (eg[p] || !v[p])                 m_st[p] = 0;
            else if (el[p] && m_st[p] < STARVE) m_st[p] = m_st[p] + 1;
        end
        if (eg[0])      m_rr = 1;
        else if (eg[1]) m_rr = 0;
        m_last_g = eg;
    endtask

    function automatic logic [15:0] pick();
        int r;
        r = $urandom_range(0, 7);
        case (r)
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'h0000;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    logic [1:0]  pv;
    logic [15:0] pa [2];
    logic [15:0] pb [2];
    logic [1:0]  ps;
    logic [1:0]  seq [4];

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_sub   = 2'b00;
        rsp_ready = 2'b00;
        model_reset();

        // Reset state, including requests ignored while in reset
        #3;
        req_valid = 2'b11;
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_sum",   rsp_sum, 32'h0);
        chk("rst_flags", 32'(rsp_flags), 32'h0);
        req_valid = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single add on port 0
        step(2'b01, 16'h0003, 16'h0004, 1'b0, 16'h0, 16'h0, 1'b0, 2'b11);
        chk("add_ready", 32'(req_ready), 32'h1);
        step(2'b00, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 2'b11);
        chk("add_sum", 32'(rsp_sum[15:0]), 32'h0007);
        chk("add_flags", 32'(rsp_flags[2:0]), 32'h0);

        // Saturation on port 1
        step(2'b10, 16'h0, 16'h0, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 2'b11);
        step(2'b00, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 2'b11);
        chk("sat_pos", 32'(rsp_sum[31:16]), 32'h7FFF);
`ifdef ADDER_ARB_FLAGS_EN
        chk("sat_pos_v", 32'(rsp_flags[3]), 32'h1);
`endif
        step(2'b10, 16'h0, 16'h0, 1'b0, 16'h8000, 16'h0001, 1'b1, 2'b11);
        step(2'b00, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 2'b11);
        chk("sat_neg", 32'(rsp_sum[31:16]), 32'h8000);

        // Zero result from subtraction
        step(2'b01, 16'h1234, 16'h1234, 1'b1, 16'h0, 16'h0, 1'b0, 2'b11);
        step(2'b00, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 2'b11);
        chk("zero_sum", 32'(rsp_sum[15:0]), 32'h0);
`ifdef ADDER_ARB_FLAGS_EN
        chk("zero_flags", 32'(rsp_flags[2:0]), 32'h2);
`else
        chk("zero_flags", 32'(rsp_flags), 32'h0);
`endif

        // Backpressure on port 0 while port 1 keeps being served
        step(2'b01, 16'h0100, 16'h0020, 1'b0, 16'h0, 16'h0, 1'b0, 2'b00);
        step(2'b01, 16'h0555, 16'h0001, 1'b0, 16'h0, 16'h0, 1'b0, 2'b00);
        chk("bp_noready", 32'(req_ready), 32'h0);
        chk("bp_hold", 32'(rsp_sum[15:0]), 32'h0120);
        step(2'b11, 16'h0555, 16'h0001, 1'b0, 16'h0010, 16'h0002, 1'b1, 2'b00);
        chk("bp_port1", 32'(req_ready), 32'h2);
        step(2'b01, 16'h0555, 16'h0001, 1'b0, 16'h0, 16'h0, 1'b0, 2'b01);
        chk("bp_release", 32'(req_ready), 32'h1);
        step(2'b00, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 2'b00);
        chk("bp_new", 32'(rsp_sum[15:0]), 32'h0556);
        step(2'b00, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 2'b11);

        // Async reset with both slots full
        step(2'b01, 16'h0005, 16'h0006, 1'b0, 16'h0, 16'h0, 1'b0, 2'b00);
        step(2'b10, 16'h0, 16'h0, 1'b0, 16'h0007, 16'h0008, 1'b0, 2'b00);
        step(2'b00, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 2'b00);
        chk("pre_rst_valid", 32'(rsp_valid), 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(rsp_valid), 32'h0);
        chk("async_rst_sum", rsp_sum, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Contention after reset: grants alternate starting at port 0
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 16'h1000, 16'(i), 1'b0, 16'h2000, 16'(i), 1'b1, 2'b11);
            seq[i] = req_ready;
        end
        for (int i = 0; i < 4; i++) begin
            chk("cont_grant", 32'(seq[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
        end

        // Randomized traffic; ungranted requests hold their operands
        pv = 2'b00;
        ps = 2'b00;
        for (int p = 0; p < 2; p++) begin
            pa[p] = '0;
            pb[p] = '0;
        end
        for (int c = 0; c < 2000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!(pv[p] && !m_last_g[p])) begin
                    pv[p] = ($urandom_range(0, 3) != 0);
                    pa[p] = pick();
                    pb[p] = pick();
                    ps[p] = 1'($urandom);
                end
            end
            step(pv, pa[0], pb[0], ps[0], pa[1], pb[1], ps[1],
                 {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
